sm_sum_fifo: RTL and testbench

- Downstream stage of the sum-every-3 block. Captures each valid 6-bit sum (i_dval/i) into a small FIFO and presents it to a consumer through a valid/ready handshake.
- The producer cannot stall, so the block absorbs bursts.
- On a push into a full FIFO with no simultaneous pop, the sum is dropped and a sticky overflow flag is raised.

---
 rtl/sm_sum_fifo.sv | 140 ++++++++++++++
 tb/tb_sm_sum_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sm_sum_fifo.sv
// Small show-ahead FIFO behind the sum-every-3 stage: absorbs non-stallable pushes and flags drops.
// Optional running-maximum output o_peak is enabled by defining SM_SUM_FIFO_PEAK_EN.
module sm_sum_fifo #(
    parameter int DW    = 6,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_dval,
    input  logic [DW-1:0] i,
    input  logic          i_clr,
    output logic          o_dval,
    output logic [DW-1:0] o,
    input  logic          i_rdy,
    output logic [AW:0]   o_cnt,
    output logic          o_ovf
`ifdef SM_SUM_FIFO_PEAK_EN
    ,
    output logic [DW-1:0] o_peak
`endif
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic nempty_s;
    logic full_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic wr_en_s;

    assign nempty_s = (cnt_q != {(AW+1){1'b0}});
    assign full_s   = (cnt_q == FULL_CNT);
    assign pop_s    = nempty_s && i_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_s   = i_dval && (!full_s || pop_s);
    assign drop_s   = i_dval && full_s && !pop_s;

    // Next-state for pointers, occupancy and the sticky overflow flag; flush wins.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wr_en_s = 1'b0;
        if (i_clr) begin
            wptr_d  = {AW{1'b0}};
            rptr_d  = {AW{1'b0}};
            cnt_d   = {(AW+1){1'b0}};
            ovf_d   = 1'b0;
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = push_s;
            if (push_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
            if (drop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= {AW{1'b0}};
            rptr_q <= {AW{1'b0}};
            cnt_q  <= {(AW+1){1'b0}};
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Storage array; contents are only meaningful between rptr and wptr, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wptr_q] <= i;
        end
    end

    assign o_dval = nempty_s;
    assign o      = nempty_s ? mem_q[rptr_q] : {DW{1'b0}};
    assign o_cnt  = cnt_q;
    assign o_ovf  = ovf_q;

`ifdef SM_SUM_FIFO_PEAK_EN
    logic [DW-1:0] peak_q, peak_d;

    // Running maximum over accepted pushes only; dropped sums never reach it.
    always_comb begin
        peak_d = peak_q;
        if (i_clr) begin
            peak_d = {DW{1'b0}};
        end else if (push_s && (i > peak_q)) begin
            peak_d = i;
        end else begin
            peak_d = peak_q;
        end
    end

    // Peak register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= {DW{1'b0}};
        end else begin
            peak_q <= peak_d;
        end
    end

    assign o_peak = peak_q;
`endif

endmodule

// File: tb/tb_sm_sum_fifo.sv
// Self-checking bench for sm_sum_fifo: queue-based reference model compared every cycle,
// plus directed checks with hand-computed values. Covers o_peak when SM_SUM_FIFO_PEAK_EN is defined.
module tb_sm_sum_fifo;

    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          i_dval;
    logic [DW-1:0] i;
    logic          i_clr;
    logic          o_dval;
    logic [DW-1:0] o;
    logic          i_rdy;
    logic [AW:0]   o_cnt;
    logic          o_ovf;
`ifdef SM_SUM_FIFO_PEAK_EN
    logic [DW-1:0] o_peak;
`endif

    int checks   = 0;
    int failures = 0;

    sm_sum_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_dval (i_dval),
        .i      (i),
        .i_clr  (i_clr),
        .o_dval (o_dval),
        .o      (o),
        .i_rdy  (i_rdy),
        .o_cnt  (o_cnt),
        .o_ovf  (o_ovf)
`ifdef SM_SUM_FIFO_PEAK_EN
        ,
        .o_peak (o_peak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of accepted sums, sticky drop flag and running max.
    logic [DW-1:0] m_q[$];
    logic          m_ovf  = 1'b0;
    logic [DW-1:0] m_peak = '0;

    always @(posedge clk or negedge rst) begin
        bit m_pop, m_push;
        if (!rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_peak = '0;
        end else if (i_clr) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_peak = '0;
        end else begin
            m_pop  = (m_q.size() != 0) && i_rdy;
            m_push = i_dval && ((m_q.size() < DEPTH) || m_pop);
            if (i_dval && !m_push) m_ovf = 1'b1;
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin
                m_q.push_back(i);
                if (i > m_peak) m_peak = i;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_o_dval", int'(o_dval), int'(m_q.size() != 0));
        chk("cyc_o", int'(o), (m_q.size() != 0) ? int'(m_q[0]) : 0);
        chk("cyc_o_cnt", int'(o_cnt), m_q.size());
        chk("cyc_o_ovf", int'(o_ovf), int'(m_ovf));
`ifdef SM_SUM_FIFO_PEAK_EN
        chk("cyc_o_peak", int'(o_peak), int'(m_peak));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic dv, input int val, input logic rdy);
        i_dval = dv;
        i      = DW'(val);
        i_rdy  = rdy;
    endtask

    int exp_seq3[4] = '{11, 12, 13, 20};

    initial begin
        rst = 1'b0; i_dval = 1'b0; i = '0; i_clr = 1'b0; i_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", int'(o_cnt), 0);
        chk("rst_dval", int'(o_dval), 0);
        chk("rst_o", int'(o), 0);
        chk("rst_ovf", int'(o_ovf), 0);
        rst = 1'b1;
        cyc();

        // Pass-through with consumer always ready
        drive(1'b1, 5, 1'b1);  cyc(); chk("t1_o5", int'(o), 5);  chk("t1_cnt", int'(o_cnt), 1);
        drive(1'b1, 9, 1'b1);  cyc(); chk("t1_o9", int'(o), 9);  chk("t1_cnt", int'(o_cnt), 1);
        drive(1'b1, 13, 1'b1); cyc(); chk("t1_o13", int'(o), 13); chk("t1_cnt", int'(o_cnt), 1);
        drive(1'b0, 0, 1'b1);  cyc(); chk("t1_empty", int'(o_dval), 0); chk("t1_ovf", int'(o_ovf), 0);

        // Fill, overflow, drain
        drive(1'b1, 1, 1'b0); cyc();
        drive(1'b1, 2, 1'b0); cyc();
        drive(1'b1, 3, 1'b0); cyc();
        drive(1'b1, 4, 1'b0); cyc();
        chk("t2_full_cnt", int'(o_cnt), 4); chk("t2_ovf_pre", int'(o_ovf), 0);
        drive(1'b1, 7, 1'b0); cyc();
        chk("t2_cnt", int'(o_cnt), 4); chk("t2_ovf", int'(o_ovf), 1);
        drive(1'b0, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("t2_drain", int'(o), k + 1);
            cyc();
        end
        chk("t2_dval0", int'(o_dval), 0); chk("t2_o0", int'(o), 0); chk("t2_ovf_stk", int'(o_ovf), 1);

        // Push into full with simultaneous pop
        drive(1'b0, 0, 1'b0); i_clr = 1'b1; cyc(); i_clr = 1'b0;
        chk("t3_clr_ovf", int'(o_ovf), 0);
        for (int k = 10; k < 14; k++) begin
            drive(1'b1, k, 1'b0); cyc();
        end
        drive(1'b1, 20, 1'b1);
        chk("t3_head", int'(o), 10);
        cyc();
        chk("t3_cnt", int'(o_cnt), 4); chk("t3_ovf", int'(o_ovf), 0);
        drive(1'b0, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("t3_drain", int'(o), exp_seq3[k]);
            cyc();
        end
        chk("t3_empty", int'(o_dval), 0);

        // Wrap-around with occupancy held at 2
        drive(1'b1, 0, 1'b0); cyc();
        drive(1'b1, 1, 1'b0); cyc();
        for (int k = 2; k < 10; k++) begin
            drive(1'b1, k, 1'b1);
            chk("t4_seq", int'(o), k - 2);
            chk("t4_cnt", int'(o_cnt), 2);
            cyc();
        end
        drive(1'b0, 0, 1'b1);
        chk("t4_seq8", int'(o), 8); cyc();
        chk("t4_seq9", int'(o), 9); cyc();
        chk("t4_empty", int'(o_dval), 0);

        // Flush with a concurrent push, after an overflow
        for (int k = 1; k < 6; k++) begin
            drive(1'b1, k, 1'b0); cyc();
        end
        drive(1'b0, 0, 1'b1); cyc();
        chk("t5_cnt3", int'(o_cnt), 3); chk("t5_ovf1", int'(o_ovf), 1);
        drive(1'b1, 63, 1'b0); i_clr = 1'b1; cyc(); i_clr = 1'b0;
        chk("t5_clr_cnt", int'(o_cnt), 0); chk("t5_clr_dval", int'(o_dval), 0);
        chk("t5_clr_ovf", int'(o_ovf), 0);
        drive(1'b0, 0, 1'b0); cyc();
        chk("t5_no63", int'(o_cnt), 0);

        // Asynchronous reset mid-stream
        drive(1'b1, 33, 1'b0); cyc();
        drive(1'b1, 34, 1'b0); cyc();
        drive(1'b0, 0, 1'b0);
        chk("t5_pre_rst", int'(o_cnt), 2);
        #2 rst = 1'b0;
        #1;
        chk("t5_arst_cnt", int'(o_cnt), 0); chk("t5_arst_dval", int'(o_dval), 0);
        chk("t5_arst_o", int'(o), 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_post_rst", int'(o_cnt), 0);

`ifdef SM_SUM_FIFO_PEAK_EN
        // Running maximum ignores the dropped sum
        drive(1'b1, 12, 1'b0); cyc();
        drive(1'b1, 45, 1'b0); cyc();
        drive(1'b1, 30, 1'b0); cyc();
        drive(1'b1, 5, 1'b0);  cyc();
        drive(1'b1, 63, 1'b0); cyc();
        chk("t6_ovf", int'(o_ovf), 1);
        chk("t6_peak", int'(o_peak), 45);
        drive(1'b0, 0, 1'b0); i_clr = 1'b1; cyc(); i_clr = 1'b0;
        chk("t6_peak_clr", int'(o_peak), 0);
`endif

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
